// File: rtl/ext_mem_arbiter.sv
// Arbiter sharing one external memory word port between the I-side and D-side
// miss controllers: transaction-locked grants, round-robin ties, ack watchdog.
module ext_mem_arbiter #(
  parameter int unsigned WORD_SIZE = 32,
  parameter int unsigned TIMEOUT   = 255
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [31:0]          i_addr,
  input  logic                 i_re,
  input  logic                 i_wr,
  input  logic [WORD_SIZE-1:0] i_data_out,
  output logic [WORD_SIZE-1:0] i_data_in,
  output logic                 i_ack,
  input  logic [31:0]          d_addr,
  input  logic                 d_re,
  input  logic                 d_wr,
  input  logic [WORD_SIZE-1:0] d_data_out,
  output logic [WORD_SIZE-1:0] d_data_in,
  output logic                 d_ack,
  output logic [31:0]          mem_addr,
  output logic                 mem_re,
  output logic                 mem_wr,
  output logic [WORD_SIZE-1:0] mem_data_out,
  input  logic [WORD_SIZE-1:0] mem_data_in,
  input  logic                 mem_ack,
  output logic                 busy,
  output logic                 grant_d,
  output logic                 timeout_err
);

  typedef enum logic [1:0] {IDLE, GRANT_I, GRANT_D, RELEASE} state_e;

  localparam bit         WD_EN    = (TIMEOUT != 0);
  localparam logic [7:0] WD_LIMIT = WD_EN ? 8'(TIMEOUT - 1) : 8'd0;

  state_e     state_q, state_d;
  logic       last_owner_q, last_owner_d;  // 1: D-side owned the port last
  logic [7:0] wd_cnt_q, wd_cnt_d;
  logic       timeout_err_q, timeout_err_d;
  logic       i_blocked_q, i_blocked_d;
  logic       d_blocked_q, d_blocked_d;

  logic i_any, d_any, req_i, req_d, owner_is_d, owner_any, wd_fire;

  always_comb begin
    // NOTE: every signal gets a default first so no latch is inferred.
    i_any         = i_re | i_wr;
    d_any         = d_re | d_wr;
    req_i         = i_any & ~i_blocked_q;
    req_d         = d_any & ~d_blocked_q;
    owner_is_d    = (state_q == GRANT_D);
    owner_any     = owner_is_d ? d_any : i_any;
    wd_fire       = WD_EN && (wd_cnt_q == WD_LIMIT) && !mem_ack;
    state_d       = state_q;
    last_owner_d  = last_owner_q;
    wd_cnt_d      = wd_cnt_q;
    timeout_err_d = timeout_err_q;
    // A watchdog block lasts until the blocked side drops its request once.
    i_blocked_d   = i_blocked_q & i_any;
    d_blocked_d   = d_blocked_q & d_any;

    unique case (state_q)
      IDLE: begin
        wd_cnt_d = '0;
        if (req_i && req_d) state_d = last_owner_q ? GRANT_I : GRANT_D;
        else if (req_i)     state_d = GRANT_I;
        else if (req_d)     state_d = GRANT_D;
      end
      GRANT_I, GRANT_D: begin
        if (mem_ack)                wd_cnt_d = '0;
        else if (wd_cnt_q != 8'hFF) wd_cnt_d = wd_cnt_q + 8'd1;
        if (wd_fire) begin
          timeout_err_d = 1'b1;
          last_owner_d  = owner_is_d;
          state_d       = RELEASE;
          if (owner_is_d) d_blocked_d = 1'b1;
          else            i_blocked_d = 1'b1;
        end else if (!owner_any) begin
          last_owner_d = owner_is_d;
          state_d      = RELEASE;
        end
      end
      RELEASE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Port steering: only the owner is connected; everything else reads as zero.
  always_comb begin
    mem_addr     = '0;
    mem_re       = 1'b0;
    mem_wr       = 1'b0;
    mem_data_out = '0;
    i_ack        = 1'b0;
    i_data_in    = '0;
    d_ack        = 1'b0;
    d_data_in    = '0;
    if (state_q == GRANT_I) begin
      mem_addr     = i_addr;
      mem_re       = i_re;
      mem_wr       = i_wr;
      mem_data_out = i_data_out;
      i_ack        = mem_ack;
      i_data_in    = mem_data_in;
    end else if (state_q == GRANT_D) begin
      mem_addr     = d_addr;
      mem_re       = d_re;
      mem_wr       = d_wr;
      mem_data_out = d_data_out;
      d_ack        = mem_ack;
      d_data_in    = mem_data_in;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state is updated with non-blocking assignments only.
    if (rst) begin
      state_q       <= IDLE;
      last_owner_q  <= 1'b1;
      wd_cnt_q      <= '0;
      timeout_err_q <= 1'b0;
      i_blocked_q   <= 1'b0;
      d_blocked_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      last_owner_q  <= last_owner_d;
      wd_cnt_q      <= wd_cnt_d;
      timeout_err_q <= timeout_err_d;
      i_blocked_q   <= i_blocked_d;
      d_blocked_q   <= d_blocked_d;
    end
  end

  assign busy        = (state_q == GRANT_I) || (state_q == GRANT_D);
  assign grant_d     = (state_q == GRANT_D);
  assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_ext_mem_arbiter.sv
// Scoreboard bench for ext_mem_arbiter: stimulus pushes expected grants/acks,
// a negedge monitor pops and compares; a small memory model answers strobes.
module tb_ext_mem_arbiter;
  localparam int W = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic [1:0]    rq_re, rq_wr;
  logic [31:0]   rq_addr [2];
  logic [W-1:0]  rq_wdata [2];
  int            left [2];
  logic [W-1:0]  i_data_in, d_data_in, mem_data_out, mem_data_in;
  logic [31:0]   mem_addr;
  logic          i_ack, d_ack, mem_re, mem_wr, mem_ack, busy, grant_d, timeout_err;

  typedef struct {
    logic        is_d;
    logic [31:0] addr;
    logic        re;
    logic        wr;
    logic [31:0] wdata;
  } grant_t;

  grant_t      grant_exp[$];
  logic [31:0] ack_exp_i[$];
  logic [31:0] ack_exp_d[$];

  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  logic        mon_en   = 1'b0;
  logic        busy_prev = 1'b0;
  logic [1:0]  ack_seen = 2'b00;
  logic        resp_en = 1'b0, resp_force = 1'b0;
  int          resp_gap = 0;
  int          wait_cnt = 0;
  logic [15:0] beat = '0;

  ext_mem_arbiter #(.WORD_SIZE(W), .TIMEOUT(4)) dut (
    .clk(clk), .rst(rst),
    .i_addr(rq_addr[0]), .i_re(rq_re[0]), .i_wr(rq_wr[0]), .i_data_out(rq_wdata[0]),
    .i_data_in(i_data_in), .i_ack(i_ack),
    .d_addr(rq_addr[1]), .d_re(rq_re[1]), .d_wr(rq_wr[1]), .d_data_out(rq_wdata[1]),
    .d_data_in(d_data_in), .d_ack(d_ack),
    .mem_addr(mem_addr), .mem_re(mem_re), .mem_wr(mem_wr), .mem_data_out(mem_data_out),
    .mem_data_in(mem_data_in), .mem_ack(mem_ack),
    .busy(busy), .grant_d(grant_d), .timeout_err(timeout_err)
  );

  initial forever #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish, required finish before 100us");
    $fatal(1);
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: got an event with nothing expected", name);
  endtask

  task automatic push_ack(input int s, input logic [31:0] data);
    if (s == 0) ack_exp_i.push_back(data);
    else        ack_exp_d.push_back(data);
  endtask

  // Raise a request; nbeats>0 lets the requester drop it after that many acks.
  task automatic start(input int s, input logic re, input logic wr, input logic [31:0] addr,
                       input logic [31:0] wdata, input int nbeats, input bit exp);
    grant_t g;
    rq_re[s]    = re;
    rq_wr[s]    = wr;
    rq_addr[s]  = addr;
    rq_wdata[s] = wdata;
    left[s]     = nbeats;
    if (exp) begin
      g.is_d = (s == 1); g.addr = addr; g.re = re; g.wr = wr; g.wdata = wdata;
      grant_exp.push_back(g);
      for (int b = 0; b < nbeats; b++) push_ack(s, {addr[15:0], 16'(b)});
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((busy || left[0] != 0 || left[1] != 0 || rq_re != 2'b00 || rq_wr != 2'b00) && n < 300) begin
      tick();
      n++;
    end
    if (n >= 300) unexpected("wait_idle_timeout");
    tick();
    tick();
  endtask

  // Requester model: drop the request the cycle after its last expected ack.
  initial forever begin
    @(posedge clk);
    #1;
    for (int s = 0; s < 2; s++) begin
      if (ack_seen[s] && left[s] > 0) begin
        left[s]--;
        if (left[s] == 0) begin
          rq_re[s] = 1'b0;
          rq_wr[s] = 1'b0;
        end
      end
    end
  end

  // Memory model: ack after resp_gap waiting cycles; read data encodes addr and beat.
  initial begin
    mem_ack     = 1'b0;
    mem_data_in = '1;
    forever begin
      @(posedge clk);
      #3;
      if (resp_force) begin
        mem_ack     = 1'b1;
        mem_data_in = {mem_addr[15:0], beat};
        resp_force  = 1'b0;
      end else if (resp_en && (mem_re || mem_wr)) begin
        if (wait_cnt >= resp_gap) begin
          mem_ack     = 1'b1;
          mem_data_in = {mem_addr[15:0], beat};
          beat        = beat + 16'd1;
          wait_cnt    = 0;
        end else begin
          mem_ack     = 1'b0;
          mem_data_in = '1;
          wait_cnt++;
        end
      end else begin
        mem_ack     = 1'b0;
        mem_data_in = '1;
        wait_cnt    = 0;
        beat        = '0;
      end
    end
  end

  // Monitor: grant starts and acks are popped against the scoreboard queues.
  initial forever begin
    grant_t g;
    logic [31:0] e;
    @(negedge clk);
    ack_seen = {d_ack, i_ack};
    if (mon_en) begin
      if (busy && !busy_prev) begin
        if (grant_exp.size() == 0) unexpected("grant");
        else begin
          g = grant_exp.pop_front();
          check("grant_owner", grant_d, g.is_d);
          check("grant_mem_addr", mem_addr, g.addr);
          check("grant_mem_re", mem_re, g.re);
          check("grant_mem_wr", mem_wr, g.wr);
          check("grant_mem_data_out", mem_data_out, g.wdata);
        end
      end
      if (i_ack) begin
        if (ack_exp_i.size() == 0) unexpected("i_ack");
        else begin
          e = ack_exp_i.pop_front();
          check("i_data_in", i_data_in, e);
        end
      end
      if (d_ack) begin
        if (ack_exp_d.size() == 0) unexpected("d_ack");
        else begin
          e = ack_exp_d.pop_front();
          check("d_data_in", d_data_in, e);
        end
      end
      if (!(busy && !grant_d)) check("i_side_quiet", {i_ack, i_data_in}, '0);
      if (!(busy && grant_d))  check("d_side_quiet", {d_ack, d_data_in}, '0);
      if (!busy) check("mem_port_quiet", {mem_re, mem_wr, mem_addr, mem_data_out}, '0);
      busy_prev = busy;
    end
  end

  initial begin
    int n;
    int t_drop;
    int w;
    logic [31:0] addr_w [3];
    addr_w[0] = 32'h0000_0A00;
    addr_w[1] = 32'h0000_0B00;
    addr_w[2] = 32'h0000_0C00;
    rst = 1'b1;
    rq_re = '0; rq_wr = '0;
    for (int s = 0; s < 2; s++) begin
      rq_addr[s] = '0; rq_wdata[s] = '0; left[s] = 0;
    end

    // Reset state
    repeat (3) tick();
    mon_en = 1'b1;
    sample();
    check("rst_busy", busy, 0);
    check("rst_grant_d", grant_d, 0);
    check("rst_timeout_err", timeout_err, 0);
    check("rst_strobes", {mem_re, mem_wr}, 0);
    check("rst_acks", {i_ack, d_ack}, 0);
    tick();
    rst = 1'b0;

    // Tie after reset goes to I; D follows 3 cycles after i_re drops
    tick();
    resp_en = 1'b1; resp_gap = 0;
    start(0, 1'b1, 1'b0, 32'h0000_0100, 32'h1111_1111, 16, 1'b1);
    start(1, 1'b1, 1'b0, 32'h0000_0200, 32'h2222_2222, 2, 1'b1);
    tick();
    sample();
    check("t1_busy", busy, 1);
    check("t1_grant_d", grant_d, 0);
    check("t1_mem_addr", mem_addr, 32'h0000_0100);
    check("t1_d_ack", d_ack, 0);
    n = 0;
    while (rq_re[0] && n < 100) begin sample(); n++; end
    t_drop = cyc;
    n = 0;
    while (!(grant_d && mem_re) && n < 100) begin sample(); n++; end
    check("t1_gap_cycles", cyc - t_drop, 3);
    check("t1_d_mem_addr", mem_addr, 32'h0000_0200);
    wait_idle();

    // Ties where the loser withdraws: winners alternate I, D, I
    for (int r = 0; r < 3; r++) begin
      w = r % 2;
      start(w, 1'b1, 1'b0, addr_w[r], 32'h0, 1, 1'b1);
      start(1 - w, 1'b1, 1'b0, 32'h0000_0F00, 32'h0, 0, 1'b0);
      tick();
      sample();
      check("t2_busy", busy, 1);
      check("t2_grant_d", grant_d, w[0]);
      tick();
      rq_re[1 - w] = 1'b0;
      wait_idle();
    end

    // D word write with ack after 2 waiting cycles
    resp_gap = 2;
    start(1, 1'b0, 1'b1, 32'h0000_1040, 32'hDEAD_BEEF, 1, 1'b1);
    push_ack(1, 32'h0);
    void'(ack_exp_d.pop_back());
    tick();
    sample();
    check("t3_mem_wr", {mem_re, mem_wr}, 2'b01);
    check("t3_mem_data_out", mem_data_out, 32'hDEAD_BEEF);
    check("t3_mem_addr", mem_addr, 32'h0000_1040);
    wait_idle();
    resp_gap = 0;

    // Watchdog: 4 silent grant cycles abort I; I stays blocked until it drops
    resp_en = 1'b0;
    start(0, 1'b1, 1'b0, 32'h0000_0300, 32'h0, 0, 1'b1);
    repeat (4) tick();
    sample();
    check("t4_busy_before", busy, 1);
    check("t4_err_before", timeout_err, 0);
    tick();
    sample();
    check("t4_busy_after", busy, 0);
    check("t4_err_after", timeout_err, 1);
    tick();
    resp_en = 1'b1;
    start(1, 1'b1, 1'b0, 32'h0000_0400, 32'h0, 2, 1'b1);
    n = 0;
    while ((left[1] != 0 || busy) && n < 100) begin tick(); n++; end
    repeat (4) begin
      tick();
      sample();
      check("t4_i_blocked", busy, 0);
    end
    check("t4_err_sticky", timeout_err, 1);
    tick();
    rq_re[0] = 1'b0;
    tick();
    start(0, 1'b1, 1'b0, 32'h0000_0300, 32'h0, 1, 1'b1);
    wait_idle();

    // Reset in the middle of a D fill: three acks land, then the fill is abandoned
    start(1, 1'b1, 1'b0, 32'h0000_0500, 32'h0, 0, 1'b1);
    push_ack(1, 32'h0500_0000);
    push_ack(1, 32'h0500_0001);
    push_ack(1, 32'h0500_0002);
    repeat (3) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    rq_re[1] = 1'b0;
    sample();
    check("t5_mem_re", mem_re, 0);
    check("t5_busy", busy, 0);
    check("t5_timeout_err", timeout_err, 0);
    check("t5_d_ack", d_ack, 0);
    tick();
    start(0, 1'b1, 1'b0, 32'h0000_0600, 32'h0, 2, 1'b1);
    wait_idle();

    // Owner drops its request in the same cycle as mem_ack
    resp_en = 1'b0;
    start(1, 1'b1, 1'b0, 32'h0000_0700, 32'h0, 0, 1'b1);
    tick();
    tick();
    rq_re[1]   = 1'b0;
    resp_force = 1'b1;
    push_ack(1, 32'h0700_0000);
    sample();
    check("t6_d_ack", d_ack, 1);
    check("t6_mem_re", mem_re, 0);
    tick();
    sample();
    check("t6_busy_release", busy, 0);
    check("t6_d_ack_after", d_ack, 0);

    tick();
    check("grant_queue_empty", grant_exp.size(), 0);
    check("i_ack_queue_empty", ack_exp_i.size(), 0);
    check("d_ack_queue_empty", ack_exp_d.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
